// File: rtl/execute.sv
// execute: single-issue execute stage with one-cycle ALU/memory/branch ops and a 16-cycle shift-add multiplier
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  op,
  input  logic [15:0] src1,
  input  logic [15:0] src2,
  input  logic [15:0] imm,
  input  logic [15:0] pc,
  input  logic [3:0]  dst,
  output logic        stall,
  output logic [15:0] val1,
  output logic [15:0] val2,
  output logic [15:0] val3,
  output logic        is_mem_read,
  output logic        is_mem_write,
  output logic        is_reg_write,
  output logic        do_branch,
  output logic [15:0] branch_addr,
  output logic        do_exe_mem_write,
  output logic [15:0] exe_mem_result,
  output logic [15:0] exe_mem_addr
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state;
  logic [3:0] cnt, mdst;
  logic [15:0] ma, mb, acc, sum, alu;
  logic take, is_alu;
  assign stall = state == MUL;
  assign take = in_valid && !stall && !do_branch;
  assign is_alu = op >= 4'd1 && op <= 4'd5;
  assign sum = acc + (mb[0] ? ma : 16'd0);
  always_comb begin
    alu = op == 4'd1 ? src1 + src2 :
          op == 4'd2 ? src1 - src2 :
          op == 4'd3 ? src1 & src2 :
          op == 4'd4 ? src1 | src2 : src1 << src2[3:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {cnt, mdst, ma, mb, acc} <= '0;
      {val1, val2, val3, is_mem_read, is_mem_write, is_reg_write} <= '0;
      {do_branch, branch_addr, do_exe_mem_write, exe_mem_result, exe_mem_addr} <= '0;
    end else begin
      {val1, val2, val3, is_mem_read, is_mem_write, is_reg_write} <= '0;
      {do_branch, branch_addr, do_exe_mem_write, exe_mem_result, exe_mem_addr} <= '0;
      if (stall) begin
        acc <= sum;
        ma <= ma << 1;
        mb <= mb >> 1;
        cnt <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          state <= IDLE;
          do_exe_mem_write <= 1'b1;
          exe_mem_result <= sum;
          exe_mem_addr <= {12'b0, mdst};
        end
      end else if (take) begin
        if (is_alu) begin
          do_exe_mem_write <= 1'b1;
          exe_mem_result <= alu;
          exe_mem_addr <= {12'b0, dst};
        end
        case (op)
          4'd6: begin
            val1 <= src1;
            val2 <= imm;
            val3 <= {12'b0, dst};
            is_mem_read <= 1'b1;
            is_reg_write <= 1'b1;
          end
          4'd7: begin
            val1 <= src1;
            val2 <= imm;
            val3 <= src2;
            is_mem_write <= 1'b1;
          end
          4'd8: begin
            do_branch <= src1 == src2;
            branch_addr <= src1 == src2 ? pc + imm : 16'd0;
          end
          4'd9: begin
            do_branch <= 1'b1;
            branch_addr <= src1 + imm;
          end
          4'd10: begin
            state <= MUL;
            cnt <= '0;
            acc <= '0;
            ma <= src1;
            mb <= src2;
            mdst <= dst;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_execute.sv
// tb_execute: table-driven vectors plus hand-written branch, multiply and reset sequences
module tb_execute;
  logic clk = 0, rst = 1, in_valid = 0, stall;
  logic [3:0] op = 0, dst = 0;
  logic [15:0] src1 = 0, src2 = 0, imm = 0, pc = 0;
  logic [15:0] val1, val2, val3, branch_addr, exe_mem_result, exe_mem_addr;
  logic is_mem_read, is_mem_write, is_reg_write, do_branch, do_exe_mem_write;
  int n_chk = 0, n_fail = 0;

  execute dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .src1(src1), .src2(src2),
    .imm(imm), .pc(pc), .dst(dst), .stall(stall), .val1(val1), .val2(val2), .val3(val3),
    .is_mem_read(is_mem_read), .is_mem_write(is_mem_write), .is_reg_write(is_reg_write),
    .do_branch(do_branch), .branch_addr(branch_addr), .do_exe_mem_write(do_exe_mem_write),
    .exe_mem_result(exe_mem_result), .exe_mem_addr(exe_mem_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [3:0] op;
    logic [15:0] s1, s2, imm, pc;
    logic [3:0] dst;
    logic [101:0] exp;
  } vec_t;

  function automatic logic [101:0] mk(logic dw, logic [15:0] res, addr, v1, v2, v3,
                                      logic mr, mw, rw, br, logic [15:0] ba);
    return {dw, res, addr, v1, v2, v3, mr, mw, rw, br, ba, 1'b0};
  endfunction

  function automatic logic [101:0] alu_exp(logic [15:0] res, logic [3:0] d);
    return mk(1'b1, res, {12'b0, d}, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endfunction

  function automatic logic [101:0] got();
    return {do_exe_mem_write, exe_mem_result, exe_mem_addr, val1, val2, val3,
            is_mem_read, is_mem_write, is_reg_write, do_branch, branch_addr, stall};
  endfunction

  task automatic chk(input string name, input logic [101:0] exp);
    n_chk++;
    if (got() !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got(), exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [15:0] a, b, i, p,
                       input logic [3:0] d);
    in_valid = v; op = o; src1 = a; src2 = b; imm = i; pc = p; dst = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{"add",       4'd1,  16'd3,      16'd4,      16'd0,    16'd0,      4'd2,  alu_exp(16'd7, 4'd2)};
    tbl[1]  = '{"sub_wrap",  4'd2,  16'd0,      16'd1,      16'd0,    16'd0,      4'd1,  alu_exp(16'hFFFF, 4'd1)};
    tbl[2]  = '{"shl_drop",  4'd5,  16'h8001,   16'd1,      16'd0,    16'd0,      4'd3,  alu_exp(16'h0002, 4'd3)};
    tbl[3]  = '{"and",       4'd3,  16'hF0F0,   16'h3C3C,   16'd0,    16'd0,      4'd4,  alu_exp(16'h3030, 4'd4)};
    tbl[4]  = '{"or",        4'd4,  16'hF000,   16'h000F,   16'd0,    16'd0,      4'd15, alu_exp(16'hF00F, 4'd15)};
    tbl[5]  = '{"shl_low4",  4'd5,  16'd1,      16'h0013,   16'd0,    16'd0,      4'd0,  alu_exp(16'd8, 4'd0)};
    tbl[6]  = '{"add_wrap",  4'd1,  16'hFFFF,   16'd2,      16'd0,    16'd0,      4'd7,  alu_exp(16'd1, 4'd7)};
    tbl[7]  = '{"load",      4'd6,  16'd2,      16'd0,      16'd3,    16'd0,      4'd5,
                mk(1'b0, 16'd0, 16'd0, 16'd2, 16'd3, 16'd5, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0)};
    tbl[8]  = '{"store",     4'd7,  16'd7,      16'd9,      16'd1,    16'd0,      4'd6,
                mk(1'b0, 16'd0, 16'd0, 16'd7, 16'd1, 16'd9, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0)};
    tbl[9]  = '{"beq_taken", 4'd8,  16'd6,      16'd6,      16'd4,    16'd10,     4'd0,
                mk(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd14)};
    tbl[10] = '{"beq_not",   4'd8,  16'd1,      16'd2,      16'd4,    16'd10,     4'd0,  '0};
    tbl[11] = '{"jmp_wrap",  4'd9,  16'hFFF0,   16'd0,      16'h0020, 16'd0,      4'd0,
                mk(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010)};
    tbl[12] = '{"nop",       4'd0,  16'd5,      16'd5,      16'd0,    16'd0,      4'd3,  '0};
    tbl[13] = '{"reserved",  4'd11, 16'd5,      16'd5,      16'd0,    16'd0,      4'd3,  '0};
    tbl[14] = '{"beq_wrap",  4'd8,  16'd0,      16'd0,      16'd3,    16'hFFFE,   4'd0,
                mk(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1)};

    tick();
    chk("reset_state", '0);
    drive(1'b1, 4'd1, 16'd3, 16'd4, 16'd0, 16'd0, 4'd2);
    tick();
    chk("held_in_reset", '0);
    rst = 0;
    tick();
    chk("first_accept", alu_exp(16'd7, 4'd2));
    drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0);
    tick();
    chk("idle_bubble", '0);

    foreach (tbl[k]) begin
      drive(1'b1, tbl[k].op, tbl[k].s1, tbl[k].s2, tbl[k].imm, tbl[k].pc, tbl[k].dst);
      tick();
      chk(tbl[k].name, tbl[k].exp);
      drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0);
      tick();
      chk({tbl[k].name, "_after"}, '0);
    end

    // branch pulse must drop the instruction presented behind it
    drive(1'b1, 4'd8, 16'd6, 16'd6, 16'd4, 16'd10, 4'd0);
    tick();
    chk("beq_pulse", mk(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd14));
    drive(1'b1, 4'd1, 16'd3, 16'd4, 16'd0, 16'd0, 4'd2);
    tick();
    chk("add_dropped", '0);
    drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0);
    tick();
    chk("post_drop_idle", '0);

    // 300*300 with a held ADD whose operands differ from the latched MUL ones
    drive(1'b1, 4'd10, 16'd300, 16'd300, 16'd0, 16'd0, 4'd9);
    tick();
    chk("mul_accept", 102'd1);
    drive(1'b1, 4'd1, 16'd3, 16'd4, 16'd0, 16'd0, 4'd2);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("mul_busy%0d", i), 102'd1);
    end
    tick();
    chk("mul_result", alu_exp(16'd24464, 4'd9));
    tick();
    chk("held_add", alu_exp(16'd7, 4'd2));
    drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0);
    tick();
    chk("post_mul_idle", '0);

    drive(1'b1, 4'd10, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 4'd12);
    tick();
    drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0);
    repeat (15) tick();
    tick();
    chk("mul_ffff_sq", alu_exp(16'd1, 4'd12));

    // asynchronous reset during iteration 7 abandons the multiply
    drive(1'b1, 4'd10, 16'd300, 16'd300, 16'd0, 16'd0, 4'd9);
    tick();
    drive(1'b0, 4'd0, 16'd0, 16'd0, 16'd0, 16'd0, 4'd0);
    repeat (7) tick();
    chk("mul_midway", 102'd1);
    #2 rst = 1;
    #1;
    chk("async_reset", '0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("no_mul_result%0d", i), '0);
    end
    drive(1'b1, 4'd2, 16'd10, 16'd3, 16'd0, 16'd0, 4'd1);
    tick();
    chk("sub_after_reset", alu_exp(16'd7, 4'd1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 Port rst  in  1  reset, asynchronous, active-high; takes effect immediately, independent of clk.
REQ-003 Port in_valid  in  1  decode presents an instruction this cycle.
REQ-004 Port op  in  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHL, 6 LOAD, 7 STORE, 8 BEQ, 9 JMP, 10 MUL, 11-15 reserved.
REQ-005 Ports src1, src2, imm, pc  in  16 each  register operands, immediate and instruction address (block = 16 bits).
REQ-006 Port dst  in  4  destination register number.
REQ-007 Port stall  out  1  execute busy; decode holds its instruction.
REQ-008 Ports val1, val2, val3  out  16 each  memory-stage operands: base, offset, data or destination.
REQ-009 Ports is_mem_read, is_mem_write, is_reg_write  out  1 each  memory-stage controls.
REQ-010 Ports do_branch  out  1 and branch_addr  out  16  redirect pulse and target.
REQ-011 Ports do_exe_mem_write  out  1, exe_mem_result  out  16, exe_mem_addr  out  16  ALU write-back and forwarding path.

Function
REQ-012 All outputs except stall shall be registered; stall shall be combinational from state only (high exactly in MUL).
REQ-013 An instruction shall be accepted at a rising edge when in_valid=1, stall=0 and do_branch=0.
REQ-014 A cycle with no accepted instruction shall register a bubble: every output 0.
REQ-015 ADD/SUB/AND/OR shall compute src1 op src2, modulo 2^16, no carry or flag outputs.
REQ-016 SHL shall compute src1 << src2[3:0]; bits shifted past bit 15 are discarded.
REQ-017 ALU ops shall register do_exe_mem_write=1, exe_mem_result=result, exe_mem_addr={12'b0,dst}; mem/branch controls 0.
REQ-018 LOAD shall register val1=src1, val2=imm, val3={12'b0,dst}, is_mem_read=1, is_reg_write=1.
REQ-019 STORE shall register val1=src1, val2=imm, val3=src2, is_mem_write=1, is_reg_write=0.
REQ-020 BEQ shall register do_branch=1, branch_addr=pc+imm (mod 2^16) if src1==src2, else a bubble.
REQ-021 JMP shall register do_branch=1, branch_addr=src1+imm (mod 2^16).
REQ-022 do_branch shall be a single-cycle pulse; the instruction presented while do_branch=1 shall be dropped (bubble registered).
REQ-023 NOP and reserved opcodes shall register a bubble.
REQ-024 States IDLE and MUL; IDLE->MUL on MUL acceptance; MUL->IDLE after 16 iterations.
REQ-025 MUL shall be shift-add, one multiplier bit per cycle, iteration counter 0..15; result = low 16 bits of src1*src2.
REQ-026 MUL accepted at edge N: stall high after edge N; bubbles registered at edges N+1..N+15; at edge N+16 the result is registered as an ALU op (REQ-017) and state returns to IDLE.
REQ-027 Operands and dst for MUL shall be latched at acceptance; input changes during MUL shall have no effect.
REQ-028 in_valid while stall=1 shall not be accepted; decode holds the instruction until stall falls.

Reset
REQ-029 While rst=1: all outputs 0, state IDLE, counter 0, latched MUL operands 0; stall=0.
REQ-030 rst asserted mid-MUL shall abandon the multiply; no result is ever produced for it.
REQ-031 First acceptance shall be at the first rising edge with rst=0.

Verification
REQ-032 ADD src1=3 src2=4 dst=2 -> next cycle do_exe_mem_write=1, exe_mem_result=7, exe_mem_addr=2; following idle cycle all 0.
REQ-033 SUB src1=0 src2=1 -> exe_mem_result=0xFFFF; SHL src1=0x8001 src2=1 -> 0x0002.
REQ-034 LOAD src1=2 imm=3 dst=5 -> val1=2, val2=3, val3=5, is_mem_read=1, is_reg_write=1; STORE src2=9 -> val3=9, is_mem_write=1.
REQ-035 BEQ src1=src2=6 pc=10 imm=4 with ADD presented next cycle -> do_branch=1, branch_addr=14 for one cycle; ADD dropped (bubble); BEQ src1=1 src2=2 -> bubble.
REQ-036 MUL 300*300 -> stall high 16 cycles, bubbles meanwhile, then exe_mem_result=24464 (90000 mod 65536); a back-to-back ADD is held and accepted at the edge stall falls.
REQ-037 rst pulsed at iteration 7 of MUL -> stall=0 and all outputs 0 immediately; no MUL result appears afterwards.
